// File: rtl/regfile_ctx_engine.sv
// Context save/restore sequencer: walks the register file and copies it to or
// from a contiguous data-memory block, acting as the register file's bus master.
module regfile_ctx_engine #(
    parameter int unsigned NREGS = 9,
    parameter int unsigned AW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] base,
    output logic          busy,
    output logic          done,
    output logic [3:0]    rf_addr,
    output logic [15:0]   rf_din,
    output logic          rf_we,
    input  logic [15:0]   rf_dout,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          mem_we,
    input  logic [15:0]   mem_rdata
);

    localparam int unsigned CW = 5;
    localparam int unsigned RW = 4;
    localparam int unsigned DW = 16;
    localparam logic [CW-1:0] LAST_REG  = CW'(NREGS - 1);
    localparam logic [CW-1:0] LAST_SAVE = CW'(NREGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAVE,
        S_RESTORE_RD,
        S_RESTORE_WR,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [RW-1:0] rf_addr_q, rf_addr_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] rf_din_q, rf_din_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;

    // Next-state and registered control outputs, decoded from the next state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        rf_addr_d  = rf_addr_q;
        mem_addr_d = mem_addr_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        rf_we_d    = 1'b0;
        mem_we_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    base_d    = base;
                    cnt_d     = '0;
                    rf_addr_d = '0;
                    busy_d    = 1'b1;
                    if (mode) begin
                        state_d    = S_RESTORE_RD;
                        mem_addr_d = base;
                    end else begin
                        state_d = S_SAVE;
                    end
                end
            end

            // cnt_q is the SAVE cycle index k; the write trails the read by one.
            S_SAVE: begin
                if (cnt_q == LAST_SAVE) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CW'(1);
                    busy_d     = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = base_q + AW'(cnt_q);
                    rf_addr_d  = (cnt_q < LAST_REG) ? RW'(cnt_q + CW'(1)) : RW'(LAST_REG);
                end
            end

            S_RESTORE_RD: begin
                state_d = S_RESTORE_WR;
                busy_d  = 1'b1;
                rf_we_d = 1'b1;
            end

            S_RESTORE_WR: begin
                if (cnt_q == LAST_REG) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = S_RESTORE_RD;
                    cnt_d      = cnt_q + CW'(1);
                    busy_d     = 1'b1;
                    rf_addr_d  = RW'(cnt_q + CW'(1));
                    mem_addr_d = base_q + AW'(cnt_q + CW'(1));
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Write data passes straight through from the one-cycle-latency read ports
    // while a write is active, and otherwise holds the last value driven.
    always_comb begin
        rf_din_d    = rf_din_q;
        mem_wdata_d = mem_wdata_q;
        if (state_q == S_RESTORE_WR) begin
            rf_din_d = mem_rdata;
        end
        if (mem_we_q) begin
            mem_wdata_d = rf_dout;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            base_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rf_addr_q   <= '0;
            rf_we_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            rf_din_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rf_addr_q   <= rf_addr_d;
            rf_we_q     <= rf_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            rf_din_q    <= rf_din_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rf_addr   = rf_addr_q;
    assign rf_we     = rf_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign rf_din    = rf_din_d;
    assign mem_wdata = mem_wdata_d;

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Directed bench for regfile_ctx_engine with behavioural register file and memory.
module tb_regfile_ctx_engine;

    localparam int unsigned NREGS = 9;
    localparam int unsigned AW    = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          mode;
    logic [AW-1:0] base;
    logic          busy;
    logic          done;
    logic [3:0]    rf_addr;
    logic [15:0]   rf_din;
    logic          rf_we;
    logic [15:0]   rf_dout;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_we;
    logic [15:0]   mem_rdata;

    logic [15:0] rf  [0:15];
    logic [15:0] mem [0:65535];

    logic          tb_rf_we;
    logic [3:0]    tb_rf_a;
    logic [15:0]   tb_rf_d;
    logic          tb_mem_we;
    logic [AW-1:0] tb_mem_a;
    logic [15:0]   tb_mem_d;

    int n_cmp;
    int n_fail;

    regfile_ctx_engine #(.NREGS(NREGS), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .base      (base),
        .busy      (busy),
        .done      (done),
        .rf_addr   (rf_addr),
        .rf_din    (rf_din),
        .rf_we     (rf_we),
        .rf_dout   (rf_dout),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file and memory: synchronous read, write on the rising edge.
    always @(posedge clk) begin
        if (rf_we) rf[rf_addr] <= rf_din;
        if (tb_rf_we) rf[tb_rf_a] <= tb_rf_d;
        rf_dout <= rf[rf_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (tb_mem_we) mem[tb_mem_a] <= tb_mem_d;
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke_rf(input logic [15:0] v0, input logic [15:0] step);
        for (int n = 0; n < int'(NREGS); n++) begin
            tb_rf_we = 1'b1;
            tb_rf_a  = 4'(n);
            tb_rf_d  = v0 + 16'(n) * step;
            tick();
        end
        tb_rf_we = 1'b0;
    endtask

    task automatic poke_mem(input logic [AW-1:0] a0, input logic [15:0] v0);
        for (int n = 0; n < int'(NREGS); n++) begin
            tb_mem_we = 1'b1;
            tb_mem_a  = a0 + AW'(n);
            tb_mem_d  = v0 + 16'(n);
            tick();
        end
        tb_mem_we = 1'b0;
    endtask

    task automatic start_xfer(input logic m, input logic [AW-1:0] b);
        start = 1'b1;
        mode  = m;
        base  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        cycles = k;
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        logic [15:0] gold [0:15];
        logic [AW-1:0] a;
        int cyc;

        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        mode      = 1'b0;
        base      = '0;
        tb_rf_we  = 1'b0;
        tb_rf_a   = '0;
        tb_rf_d   = '0;
        tb_mem_we = 1'b0;
        tb_mem_a  = '0;
        tb_mem_d  = '0;

        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_rf_din", 32'(rf_din), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        reset = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Save of 0x1000+n to 0x0200; neighbouring slots must stay untouched.
        poke_rf(16'h1000, 16'h0001);
        tb_mem_we = 1'b1; tb_mem_a = 16'h0209; tb_mem_d = 16'hBEEF; tick();
        tb_mem_a = 16'h01FF; tb_mem_d = 16'hCAFE; tick();
        tb_mem_we = 1'b0;
        start_xfer(1'b0, 16'h0200);
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) tick();
            check($sformatf("save_busy_c%0d", c), 32'(busy), 32'((c <= 10) ? 1 : 0));
            check($sformatf("save_mem_we_c%0d", c), 32'(mem_we), 32'((c >= 2 && c <= 10) ? 1 : 0));
            check($sformatf("save_rf_we_c%0d", c), 32'(rf_we), 32'd0);
            check($sformatf("save_done_c%0d", c), 32'(done), 32'((c == 11) ? 1 : 0));
            if (c >= 2 && c <= 10) begin
                check($sformatf("save_mem_addr_c%0d", c), 32'(mem_addr), 32'(16'h0200 + 16'(c - 2)));
                check($sformatf("save_mem_wdata_c%0d", c), 32'(mem_wdata), 32'(16'h1000 + 16'(c - 2)));
            end
        end
        tick();
        check("save_idle_done", 32'(done), 32'd0);
        for (int n = 0; n < 9; n++)
            check($sformatf("save_mem_%0d", n), 32'(mem[16'h0200 + 16'(n)]), 32'(16'h1000 + 16'(n)));
        check("save_mem_above", 32'(mem[16'h0209]), 32'h0000BEEF);
        check("save_mem_below", 32'(mem[16'h01FF]), 32'h0000CAFE);

        // Restore of 0xA5A0+n from 0x0300.
        poke_mem(16'h0300, 16'hA5A0);
        poke_rf(16'h0000, 16'h0000);
        start_xfer(1'b1, 16'h0300);
        for (int c = 1; c <= 19; c++) begin
            if (c > 1) tick();
            check($sformatf("rst_rf_we_c%0d", c), 32'(rf_we), 32'((c % 2 == 0 && c <= 18) ? 1 : 0));
            check($sformatf("rst_mem_we_c%0d", c), 32'(mem_we), 32'd0);
            check($sformatf("rst_busy_c%0d", c), 32'(busy), 32'((c <= 18) ? 1 : 0));
            check($sformatf("rst_done_c%0d", c), 32'(done), 32'((c == 19) ? 1 : 0));
            if (c % 2 == 1 && c <= 17)
                check($sformatf("rst_mem_addr_c%0d", c), 32'(mem_addr), 32'(16'h0300 + 16'((c - 1) / 2)));
            if (c % 2 == 0 && c <= 18) begin
                check($sformatf("rst_rf_addr_c%0d", c), 32'(rf_addr), 32'(c / 2 - 1));
                check($sformatf("rst_rf_din_c%0d", c), 32'(rf_din), 32'(16'hA5A0 + 16'(c / 2 - 1)));
            end
        end
        tick();
        for (int n = 0; n < 9; n++)
            check($sformatf("rst_rf_%0d", n), 32'(rf[n]), 32'(16'hA5A0 + 16'(n)));

        // Save across the top of the address space.
        poke_rf(16'h2000, 16'h0001);
        start_xfer(1'b0, 16'hFFFC);
        for (int c = 2; c <= 10; c++) begin
            tick();
            a = 16'hFFFC + 16'(c - 2);
            check($sformatf("wrap_mem_we_c%0d", c), 32'(mem_we), 32'd1);
            check($sformatf("wrap_mem_addr_c%0d", c), 32'(mem_addr), 32'(a));
        end
        tick();
        check("wrap_done", 32'(done), 32'd1);
        tick();
        for (int n = 0; n < 9; n++) begin
            a = 16'hFFFC + 16'(n);
            check($sformatf("wrap_mem_%0d", n), 32'(mem[a]), 32'(16'h2000 + 16'(n)));
        end

        // start held high with a mid-transfer mode/base change.
        poke_rf(16'h4000, 16'h0001);
        poke_mem(16'h0500, 16'h5500);
        start = 1'b1;
        mode  = 1'b0;
        base  = 16'h0400;
        tick();
        for (int c = 1; c <= 11; c++) begin
            if (c > 1) tick();
            check($sformatf("held_busy_c%0d", c), 32'(busy), 32'((c <= 10) ? 1 : 0));
            check($sformatf("held_done_c%0d", c), 32'(done), 32'((c == 11) ? 1 : 0));
            if (c >= 2 && c <= 10) begin
                check($sformatf("held_mem_we_c%0d", c), 32'(mem_we), 32'd1);
                check($sformatf("held_mem_addr_c%0d", c), 32'(mem_addr), 32'(16'h0400 + 16'(c - 2)));
            end
            if (c == 3) begin
                mode = 1'b1;
                base = 16'h0500;
            end
        end
        tick();
        start = 1'b0;
        check("held_restart_busy", 32'(busy), 32'd1);
        check("held_restart_done", 32'(done), 32'd0);
        check("held_restart_mem_addr", 32'(mem_addr), 32'h00000500);
        check("held_restart_rf_addr", 32'(rf_addr), 32'd0);
        check("held_restart_rf_we", 32'(rf_we), 32'd0);
        for (int n = 0; n < 9; n++)
            check($sformatf("held_mem_%0d", n), 32'(mem[16'h0400 + 16'(n)]), 32'(16'h4000 + 16'(n)));
        wait_done("held_restore_timeout", cyc);
        check("held_restore_done_cycle", 32'(cyc + 12), 32'd30);
        tick();
        for (int n = 0; n < 9; n++)
            check($sformatf("held_rf_%0d", n), 32'(rf[n]), 32'(16'h5500 + 16'(n)));

        // Reset in cycle 5 of a restore.
        poke_rf(16'h7700, 16'h0001);
        start_xfer(1'b1, 16'h0300);
        for (int c = 2; c <= 5; c++) tick();
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rf_we", 32'(rf_we), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_rf_addr", 32'(rf_addr), 32'd0);
        check("abort_rf_din", 32'(rf_din), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("abort_no_done_%0d", c), 32'(done), 32'd0);
            check($sformatf("abort_idle_busy_%0d", c), 32'(busy), 32'd0);
        end
        for (int n = 0; n < 9; n++)
            check($sformatf("abort_rf_%0d", n), 32'(rf[n]),
                  32'((n < 2) ? (16'hA5A0 + 16'(n)) : (16'h7700 + 16'(n))));

        // Save, scramble, restore to the same base.
        poke_rf(16'h3000, 16'h0007);
        for (int n = 0; n < 9; n++) gold[n] = 16'h3000 + 16'(n) * 16'h0007;
        start_xfer(1'b0, 16'h0800);
        wait_done("b2b_save_timeout", cyc);
        tick();
        poke_rf(16'hDEAD, 16'h0101);
        check("b2b_scrambled", 32'(rf[3]), 32'(16'hDEAD + 16'h0303));
        start_xfer(1'b1, 16'h0800);
        check("b2b_restore_busy", 32'(busy), 32'd1);
        wait_done("b2b_restore_timeout", cyc);
        tick();
        for (int n = 0; n < 9; n++)
            check($sformatf("b2b_rf_%0d", n), 32'(rf[n]), 32'(gold[n]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
